// File: rtl/iter_shift_unit.sv
// Multi-cycle variable shifter (SLL/SRL/SRA/ROR), STEP bits per clock.
// Start/busy/done handshake; result holds until the next completion.
module iter_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   value_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [SHAMT_W-1:0] STEP_L = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0]   WID_L  = (SHAMT_W+1)'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, done_q;

  logic [SHAMT_W-1:0] s;
  logic [SHAMT_W:0]   lsh;
  logic [WIDTH-1:0]   shifted;

  // Final step may be partial: never shift past the remaining amount.
  always_comb begin
    s       = (rem_q < STEP_L) ? rem_q : STEP_L;
    lsh     = WID_L - {1'b0, s};
    shifted = acc_q;
    unique case (op_q)
      2'b00: shifted = acc_q << s;
      2'b01: shifted = acc_q >> s;
      2'b10: shifted = $signed(acc_q) >>> s;
      2'b11: shifted = (acc_q >> s) | (acc_q << lsh);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    unique case (state_q)
      SHIFT: begin
        acc_d = shifted;
        rem_d = rem_q - s;
        if (rem_q == s) begin
          state_d  = DONE;
          result_d = shifted;
        end
      end
      default: begin
        if (start) begin
          acc_d = value_in;
          rem_d = shamt;
          op_d  = op;
          if (shamt == '0) begin
            state_d  = DONE;
            result_d = value_in;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= (state_d == SHIFT);
      done_q   <= (state_d == DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: STEP=1 and STEP=4 instances, per-cycle
// model comparison plus directed literal result/latency checks.
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st  [2];
  logic [1:0]  opv [2];
  logic [31:0] val [2];
  logic [4:0]  sa  [2];
  logic        bs  [2];
  logic        dn  [2];
  logic [31:0] rs  [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iter_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
    .clk(clk), .reset(reset), .start(st[0]), .op(opv[0]),
    .value_in(val[0]), .shamt(sa[0]),
    .busy(bs[0]), .done(dn[0]), .result(rs[0])
  );

  iter_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u4 (
    .clk(clk), .reset(reset), .start(st[1]), .op(opv[1]),
    .value_in(val[1]), .shamt(sa[1]),
    .busy(bs[1]), .done(dn[1]), .result(rs[1])
  );

  function automatic logic [31:0] ref_shift(
    input logic [1:0] o, input logic [31:0] v, input int sh);
    logic [63:0] d;
    d = {v, v} >> sh;
    case (o)
      2'b00:   return v << sh;
      2'b01:   return v >> sh;
      2'b10:   return 32'($signed(v) >>> sh);
      default: return d[31:0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: expected busy/done/result per instance, in transaction terms.
  int          stepv [2] = '{1, 4};
  logic        mb [2];
  logic        md [2];
  logic [31:0] mr [2];
  logic [31:0] pend [2];
  int          rc [2];
  bit          armed = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mb[k] = 1'b0; md[k] = 1'b0; mr[k] = '0; rc[k] = 0;
        armed = 1'b1;
      end else if (!mb[k] && st[k]) begin
        rc[k] = (int'(sa[k]) + stepv[k] - 1) / stepv[k];
        pend[k] = ref_shift(opv[k], val[k], int'(sa[k]));
        if (rc[k] == 0) begin
          md[k] = 1'b1; mr[k] = pend[k];
        end else begin
          mb[k] = 1'b1; md[k] = 1'b0;
        end
      end else if (mb[k]) begin
        md[k] = 1'b0;
        rc[k]--;
        if (rc[k] == 0) begin
          mb[k] = 1'b0; md[k] = 1'b1; mr[k] = pend[k];
        end
      end else begin
        md[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d busy", k), 32'(bs[k]), 32'(mb[k]));
        chk($sformatf("u%0d done", k), 32'(dn[k]), 32'(md[k]));
        chk($sformatf("u%0d result", k), rs[k], mr[k]);
      end
    end
  end

  // Launch a request at the current negedge; returns at the negedge
  // where done is observed (so a following call is back-to-back).
  task automatic run(input int k, input logic [1:0] o,
                     input logic [31:0] v, input logic [4:0] sh,
                     input logic [31:0] exp_r, input int exp_lat,
                     input int exp_busy, input bit glitch,
                     input string name);
    int lat;
    int bc;
    st[k] = 1'b1; opv[k] = o; val[k] = v; sa[k] = sh;
    @(negedge clk);
    st[k] = 1'b0;
    lat = 1;
    bc = 0;
    while (!dn[k] && lat < 200) begin
      if (bs[k]) bc++;
      if (glitch && lat == 2) begin
        st[k] = 1'b1; val[k] = ~v; opv[k] = o ^ 2'b01;
      end else begin
        st[k] = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    st[k] = 1'b0;
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " busy cycles"}, 32'(bc), 32'(exp_busy));
    chk({name, " result"}, rs[k], exp_r);
  endtask

  int pulses;

  initial begin
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; opv[k] = '0; val[k] = '0; sa[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(bs[0]), 32'd0);
    chk("reset done", 32'(dn[0]), 32'd0);
    chk("reset result", rs[1], 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 31, 0, "sll31");
    @(negedge clk);
    run(0, 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 5, 4, 0, "sra4");
    @(negedge clk);
    run(0, 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, 5, 4, 0, "srl4");
    @(negedge clk);
    run(1, 2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456, 3, 2, 0, "ror8 s4");
    @(negedge clk);
    run(1, 2'b11, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 9, 8, 0, "ror31 s4");
    @(negedge clk);
    run(1, 2'b10, 32'h8000_0000, 5'd5, 32'hFC00_0000, 3, 2, 0, "sra5 s4");
    @(negedge clk);

    run(0, 2'b11, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 0, 0, "zero");
    run(0, 2'b00, 32'h0000_000F, 5'd4, 32'h0000_00F0, 5, 4, 0, "b2b sll4");
    run(1, 2'b10, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 0, 0, "zero s4");
    @(negedge clk);

    run(0, 2'b01, 32'hA5A5_A5A5, 5'd6, 32'h0296_9696, 7, 6, 1, "glitch");
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (dn[0]) pulses++;
    end
    chk("glitch extra done", 32'(pulses), 32'd0);
    chk("glitch result held", rs[0], 32'h0296_9696);

    st[0] = 1'b1; opv[0] = 2'b00; val[0] = 32'h1; sa[0] = 5'd20;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 32'(bs[0]), 32'd0);
    chk("abort done", 32'(dn[0]), 32'd0);
    chk("abort result", rs[0], 32'd0);
    @(negedge clk);
    run(0, 2'b00, 32'h0000_0003, 5'd20, 32'h0030_0000, 21, 20, 0,
        "after reset");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
